// File: rtl/adder_disp_pkg.sv
// Purpose : shared types, 7-segment patterns and encoder for the adder result display.
// Latency : n/a (declarations and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   state_e     - conversion FSM states (IDLE / CONVERT / LOAD)
//   SEG_0..9    - active-high segment patterns, bit 0 = a ... bit 6 = g
//   SEG_BLANK   - all segments off
//   seg_encode  - BCD nibble to segment pattern; 10..15 show blank
package adder_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/adder_result_display_bin2bcd_seq.sv
// Purpose : sequential binary-to-BCD converter (shift-add-3 / double dabble).
// Latency : start accepted in IDLE; BIN_W shift cycles then one LOAD cycle (done_o high there).
// Backpressure: none; start_i is ignored while busy_o is high.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start_i     - begin a conversion of bin_i (only honoured in IDLE)
//   bin_i       - unsigned binary value to convert
//   busy_o      - registered, high from the accepting edge until the LOAD edge
//   done_o      - high during the LOAD cycle; bcd_o is final on that cycle
//   bcd_o       - BCD accumulator, DIGITS nibbles, units in [3:0]
module bin2bcd_seq
  import adder_disp_pkg::*;
#(
  parameter int BIN_W  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   shift_bin_q, shift_bin_d;
  logic [BCD_W-1:0]   bcd_acc_q, bcd_acc_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               busy_q, busy_d;
  logic [BCD_W-1:0]   bcd_adj;

  // Add-3 correction: any nibble >= 5 would overflow past 9 after doubling.
  always_comb begin
    bcd_adj = bcd_acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_acc_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_bin_d = shift_bin_q;
    bcd_acc_d   = bcd_acc_q;
    bit_cnt_d   = bit_cnt_q;
    busy_d      = busy_q;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shift_bin_d = bin_i;
          bcd_acc_d   = '0;
          bit_cnt_d   = '0;
          busy_d      = 1'b1;
          state_d     = CONVERT;
        end
      end
      CONVERT: begin
        // {bcd_acc, shift_bin} <<= 1 after correction
        bcd_acc_d   = {bcd_adj[BCD_W-2:0], shift_bin_q[BIN_W-1]};
        shift_bin_d = {shift_bin_q[BIN_W-2:0], 1'b0};
        bit_cnt_d   = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        done_o  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_bin_q <= '0;
      bcd_acc_q   <= '0;
      bit_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_bin_q <= shift_bin_d;
      bcd_acc_q   <= bcd_acc_d;
      bit_cnt_q   <= bit_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign bcd_o  = bcd_acc_q;

endmodule

// File: rtl/adder_result_display.sv
// Purpose : detect adder result changes, convert to BCD, drive a multiplexed 7-seg display.
// Latency : change at edge k -> busy for edges k..k+RESULT_W, disp_bcd at k+RESULT_W+1, seg one cycle later.
// Backpressure: none; changes during a conversion are picked up by the compare once back in IDLE.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   result_in   - unsigned adder result
//   seg         - registered segment drive, seg[0]=a .. seg[6]=g, active high
//   digit_sel   - registered one-hot digit enable, bit 0 = units
//   busy        - high while a conversion is in flight
//   disp_bcd    - BCD value currently displayed
// Optional: define ADDER_DISP_LEADING_ZERO_BLANK_EN to blank leading-zero digits (units never blanked).
module adder_result_display
  import adder_disp_pkg::*;
#(
  parameter int RESULT_W    = 5,
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [RESULT_W-1:0]     result_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] disp_bcd
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [RESULT_W-1:0]   last_val_q;
  logic [BCD_W-1:0]      disp_bcd_q;
  logic [CNT_W-1:0]      refresh_cnt_q, refresh_cnt_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [6:0]            seg_q, seg_d;

  logic                  conv_busy;
  logic                  conv_done;
  logic [BCD_W-1:0]      conv_bcd;
  logic                  start;
  logic [3:0]            cur_nib;
  logic                  cur_blank;

  // Converter busy covers CONVERT and LOAD, so this only fires in IDLE.
  assign start = !conv_busy && (result_in != last_val_q);

  bin2bcd_seq #(
    .BIN_W  (RESULT_W),
    .DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .bin_i   (result_in),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_val_q <= '0;
      disp_bcd_q <= '0;
    end else begin
      if (start) begin
        last_val_q <= result_in;
      end
      if (conv_done) begin
        disp_bcd_q <= conv_bcd;
      end
    end
  end

  // Refresh timing is free-running and independent of conversions.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + 1'b1;
    digit_idx_d   = digit_idx_q;
    if (refresh_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt_d = '0;
      if (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        digit_idx_d = '0;
      end else begin
        digit_idx_d = digit_idx_q + 1'b1;
      end
    end
  end

  // Select the active nibble and decide whether it is a leading zero.
  always_comb begin
    logic zero_from_here;
    cur_nib        = 4'd0;
    cur_blank      = 1'b0;
    digit_sel_d    = '0;
    zero_from_here = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      // zero_from_here: this nibble and every higher nibble are zero
      zero_from_here = zero_from_here && (disp_bcd_q[4*i +: 4] == 4'd0);
      if (digit_idx_q == IDX_W'(i)) begin
        cur_nib        = disp_bcd_q[4*i +: 4];
        digit_sel_d[i] = 1'b1;
`ifdef ADDER_DISP_LEADING_ZERO_BLANK_EN
        cur_blank      = (i != 0) && zero_from_here;
`else
        cur_blank      = 1'b0;
`endif
      end
    end
    seg_d = cur_blank ? SEG_BLANK : seg_encode(cur_nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt_q <= '0;
      digit_idx_q   <= '0;
      digit_sel_q   <= '0;
      seg_q         <= '0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
      digit_sel_q   <= digit_sel_d;
      seg_q         <= seg_d;
    end
  end

  assign seg       = seg_q;
  assign digit_sel = digit_sel_q;
  assign busy      = conv_busy;
  assign disp_bcd  = disp_bcd_q;

endmodule

// File: tb/tb_adder_result_display.sv
module tb_adder_result_display;

  localparam int RESULT_W    = 5;
  localparam int NUM_DIGITS  = 2;
  localparam int REFRESH_DIV = 4;

`ifdef ADDER_DISP_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TENS_ZERO = 7'h00;
`else
  localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [RESULT_W-1:0]     result_in;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    busy;
  logic [4*NUM_DIGITS-1:0] disp_bcd;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic busy_prev = 1'b0;

  adder_result_display #(
    .RESULT_W    (RESULT_W),
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .result_in (result_in),
    .seg       (seg),
    .digit_sel (digit_sel),
    .busy      (busy),
    .disp_bcd  (disp_bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [7:0] ref_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sel(input string tag, input logic [1:0] v);
    int n = 0;
    while (digit_sel !== v && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(digit_sel), 32'(v));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Scoreboard side: each busy falling edge is a LOAD; compare against the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_load", 32'(disp_bcd), 32'hFFFF_FFFF);
        end else begin
          chk("sb_disp_bcd", 32'(disp_bcd), 32'(exp_q.pop_front()));
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_hits;
    int bad_sel;

    // Reset state
    rst_n     = 1'b0;
    result_in = '0;
    step(3);
    chk("rst_seg",       32'(seg),       32'h00);
    chk("rst_digit_sel", 32'(digit_sel), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_disp_bcd",  32'(disp_bcd),  32'h00);

    // Release with result 0: no conversion, refresh alternates every 4 cycles
    rst_n = 1'b1;
    step(1);
    chk("first_sel", 32'(digit_sel), 32'h1);
    chk("first_seg", 32'(seg),       32'h3F);
    chk("idle_busy", 32'(busy),      32'h0);
    step(4);
    chk("sel_tens",     32'(digit_sel), 32'h2);
    chk("seg_tens_0",   32'(seg),       32'(TENS_ZERO));
    step(4);
    chk("sel_units_again", 32'(digit_sel), 32'h1);
    chk("idle_busy2",      32'(busy),      32'h0);

    // 0 -> 27: busy for edges k..k+5, disp_bcd at k+6
    result_in = 5'd27;
    exp_q.push_back(ref_bcd(27));
    step(1);
    chk("k_busy",      32'(busy), 32'h1);
    step(5);
    chk("k5_busy",     32'(busy),     32'h1);
    chk("k5_disp_old", 32'(disp_bcd), 32'h00);
    step(1);
    chk("k6_busy",     32'(busy),     32'h0);
    chk("k6_disp",     32'(disp_bcd), 32'h27);
    step(1);
    wait_sel("wait_units_27", 2'b01);
    chk("seg_units_27", 32'(seg), 32'(ref_seg(7)));
    wait_sel("wait_tens_27", 2'b10);
    chk("seg_tens_27", 32'(seg), 32'(ref_seg(2)));

    // 31, then 9 two cycles later while converting
    result_in = 5'd31;
    exp_q.push_back(ref_bcd(31));
    step(2);
    result_in = 5'd9;
    exp_q.push_back(ref_bcd(9));
    step(20);
    chk("reconv_busy", 32'(busy),     32'h0);
    chk("reconv_disp", 32'(disp_bcd), 32'h09);
    step(1);
    wait_sel("wait_tens_09", 2'b10);
    chk("seg_tens_09", 32'(seg), 32'(TENS_ZERO));
    wait_sel("wait_units_09", 2'b01);
    chk("seg_units_09", 32'(seg), 32'(ref_seg(9)));

    // Reset in the middle of a conversion of 19
    result_in = 5'd19;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg",  32'(seg),       32'h00);
    chk("mid_rst_sel",  32'(digit_sel), 32'h0);
    chk("mid_rst_busy", 32'(busy),      32'h0);
    chk("mid_rst_disp", 32'(disp_bcd),  32'h00);
    step(2);
    rst_n = 1'b1;
    exp_q.push_back(ref_bcd(19));
    step(1);
    chk("redetect_busy", 32'(busy), 32'h1);
    step(5);
    chk("redetect_k5_disp", 32'(disp_bcd), 32'h00);
    step(1);
    chk("redetect_disp", 32'(disp_bcd), 32'h19);

    // Sweep every input value
    for (int v = 0; v < 32; v++) begin
      result_in = 5'(v);
      exp_q.push_back(ref_bcd(v));
      step(1);
      wait_idle($sformatf("sweep_idle_%0d", v));
      chk($sformatf("sweep_disp_%0d", v), 32'(disp_bcd), 32'(ref_bcd(v)));
      step(2);
    end

    // Hold constant: no spurious conversions, digit_sel always one-hot
    busy_hits = 0;
    bad_sel   = 0;
    for (int c = 0; c < 1000; c++) begin
      step(1);
      if (busy !== 1'b0) busy_hits++;
      if (digit_sel !== 2'b01 && digit_sel !== 2'b10) bad_sel++;
    end
    chk("hold_busy_cycles", 32'(busy_hits), 32'd0);
    chk("hold_bad_sel",     32'(bad_sel),   32'd0);
    chk("sb_drained",       32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
